seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//   Parametrised serial pattern detector, successor to the fixed single-sequence FSM.
//   Samples serial bit a on each clock edge where ready=1 and pulses w when the last
//   LEN accepted bits equal PATTERN. Overlap or non-overlap mode is set by parameter.
//   Keeps a saturating match counter for the lab board display / bench checks.
// PARAMETERS
//   LEN      4        pattern length in bits, 2..16
//   PATTERN  4'b1011  target sequence; PATTERN[LEN-1] is the first bit received
//   OVERLAP  1        1: matches may share bits; 0: a match restarts detection from scratch
//   COUNT_W  8        width of match counter
// PORTS
//   clock   in   1        rising-edge clock
//   reset   in   1        asynchronous, active-low reset
//   a       in   1        serial data bit, sampled only when ready=1
//   ready   in   1        input qualifier; 1 = a is valid this cycle
//   clear   in   1        synchronous clear of detector state and counter
//   w       out  1        match pulse, registered, one cycle wide
//   count   out  COUNT_W  number of matches since reset/clear, saturating
//   armed   out  1        1 when LEN valid bits are held (detector can match)
// BEHAVIOUR
//   Reset (reset=0, async): hist=0, fill=0, w=0, count=0, armed=0; held while low.
//   State = fill counter, 0..LEN: FILLING (fill<LEN) -> ARMED (fill==LEN).
//     ready=1: hist <= {hist[LEN-2:0], a}; fill <= min(fill+1, LEN).
//     ready=0: hist, fill, count hold; w <= 0.
//   Match condition, evaluated on the new history: ready=1 && fill_next==LEN
//     && hist_next==PATTERN.
//     Prevents false matches on reset-zero history (e.g. PATTERN=0).
//   On match: w <= 1 for exactly one cycle (latency 1 clock after the accepting edge);
//     count <= count+1, but holds at 2^COUNT_W-1 (no wrap).
//   OVERLAP=1: fill stays LEN after a match; the next match can complete on the next bit.
//   OVERLAP=0: fill <= 0 and hist <= 0 on the match edge; the next match needs LEN new bits.
//   armed = (fill==LEN), registered.
//   clear=1 (sync): same values as reset on the next edge. Priority over ready/a.
//     w=0 even if the same edge would have matched.
//   Priority: reset > clear > ready.
//   Reset mid-sequence discards partial history; no pending w survives reset.
//   Back-to-back ready=1 gives one decision per clock; no internal stall, ready is never refused.
// TESTING (defaults unless stated)
//   T1 reset: reset=0 for 2 cycles with a/ready toggling -> w=0, count=0, armed=0 throughout.
//   T2 basic: ready=1, a=1,0,1,1 -> w=1 on the cycle after the 4th bit only; count=1; armed=1 after 4th bit.
//   T3 overlap: a=1,0,1,1,0,1,1 -> OVERLAP=1: w pulses after bits 4 and 7, count=2;
//      OVERLAP=0: w after bit 4 only, count=1, armed=0 after the match.
//   T4 ready gaps: a=1,0,(ready=0,a=0 x3),1,1 -> exactly one match; gap bits ignored; w=0 during gaps.
//   T5 fill guard + saturation: PATTERN=4'b0000, a=0 x3 -> no w; 4th 0 -> w.
//      COUNT_W=2 with 5 matches -> count=3.
//   T6 mid-op reset/clear: a=1,0,1 then reset pulse (async, between edges) then a=1 -> no w, count=0;
//      clear on the edge of a 4th bit that would match -> w=0, count=0.

Source files
------------

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector.
// Shifts in bit a on every clock where ready=1. It raises a registered one-cycle
// pulse on w when the last LEN accepted bits equal PATTERN, and it keeps a
// saturating count of matches. The fill counter stops a match from firing on the
// all-zero history left by reset or clear, so PATTERN=0 is safe. In
// non-overlapping mode a match restarts detection from an empty history.
module seq_detector_param #(
  parameter int unsigned      LEN     = 4,
  parameter logic [LEN-1:0]   PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int unsigned      COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               a,
  input  logic               ready,
  input  logic               clear,
  output logic               w,
  output logic [COUNT_W-1:0] count,
  output logic               armed
);

  localparam int unsigned         FILL_W    = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0]   FILL_FULL = FILL_W'(LEN);
  localparam logic [COUNT_W-1:0]  COUNT_MAX = '1;

  // FILLING while fewer than LEN valid bits are held; ARMED once a match is possible.
  typedef enum logic {
    S_FILLING = 1'b0,
    S_ARMED   = 1'b1
  } state_e;

  logic [LEN-1:0]     hist_q,  hist_d;
  logic [FILL_W-1:0]  fill_q,  fill_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               w_q,     w_d;
  state_e             state_q, state_d;

  logic [LEN-1:0]     hist_shift;
  logic [FILL_W-1:0]  fill_inc;
  logic               match;

  // Next-state: clear wins over ready. A match is judged on the history that includes the new bit.
  always_comb begin
    hist_d     = hist_q;
    fill_d     = fill_q;
    count_d    = count_q;
    w_d        = 1'b0;
    hist_shift = {hist_q[LEN-2:0], a};
    fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    match      = ready && (fill_inc == FILL_FULL) && (hist_shift == PATTERN);

    if (clear) begin
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (ready) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if (match) begin
        w_d = 1'b1;
        if (count_q != COUNT_MAX) begin
          count_d = count_q + COUNT_W'(1);
        end
        if (!OVERLAP) begin
          // Non-overlapping: the matched bits cannot be reused, so start over.
          hist_d = '0;
          fill_d = '0;
        end
      end
    end

    state_d = (fill_d == FILL_FULL) ? S_ARMED : S_FILLING;
  end

  // State and registered outputs. Asynchronous reset discards any partial history or pending pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      w_q     <= 1'b0;
      state_q <= S_FILLING;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      w_q     <= w_d;
      state_q <= state_d;
    end
  end

  assign w     = w_q;
  assign count = count_q;
  assign armed = (state_q == S_ARMED);

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param. Three instances share the same stimulus:
// u_ov uses the defaults (1011, overlapping), u_no is non-overlapping, and u_z
// detects 0000 with a 2-bit counter.
`timescale 1ns/1ps
module tb_seq_detector_param;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic a     = 1'b0;
  logic ready = 1'b0;
  logic clear = 1'b0;

  logic       w_ov, armed_ov;
  logic [7:0] count_ov;
  logic       w_no, armed_no;
  logic [7:0] count_no;
  logic       w_z, armed_z;
  logic [1:0] count_z;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  seq_detector_param u_ov (
    .clock(clock), .reset(reset), .a(a), .ready(ready), .clear(clear),
    .w(w_ov), .count(count_ov), .armed(armed_ov)
  );

  seq_detector_param #(.OVERLAP(1'b0)) u_no (
    .clock(clock), .reset(reset), .a(a), .ready(ready), .clear(clear),
    .w(w_no), .count(count_no), .armed(armed_no)
  );

  seq_detector_param #(.PATTERN(4'b0000), .COUNT_W(2)) u_z (
    .clock(clock), .reset(reset), .a(a), .ready(ready), .clear(clear),
    .w(w_z), .count(count_z), .armed(armed_z)
  );

  // Single comparison point: count it, report on mismatch.
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge. Outputs are sampled 1ns after the next edge.
  task automatic drive(input logic ai, input logic ri, input logic ci);
    a = ai; ready = ri; clear = ci;
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b0, 1'b1);
    clear = 1'b0;
  endtask

  // Feed n bits MSB first with ready=1 after a clear. The expected w pulse patterns are
  // given per instance. Since the history started empty, u_ov is armed once 4 bits are held.
  task automatic feed(input string tag, input logic [6:0] seq, input logic [6:0] wov,
                      input logic [6:0] wno, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      drive(seq[i], 1'b1, 1'b0);
      chk($sformatf("%s w_ov bit%0d", tag, n - i), int'(w_ov), int'(wov[i]));
      chk($sformatf("%s w_no bit%0d", tag, n - i), int'(w_no), int'(wno[i]));
      chk($sformatf("%s armed_ov bit%0d", tag, n - i), int'(armed_ov), (n - i >= 4) ? 1 : 0);
    end
  endtask

  initial begin
    // T1: reset held low while a/ready toggle
    drive(1'b1, 1'b1, 1'b0);
    chk("T1 w c1", int'(w_ov), 0);
    chk("T1 count c1", int'(count_ov), 0);
    chk("T1 armed c1", int'(armed_ov), 0);
    drive(1'b0, 1'b1, 1'b0);
    chk("T1 w c2", int'(w_ov), 0);
    chk("T1 count c2", int'(count_ov), 0);
    chk("T1 armed c2", int'(armed_ov), 0);
    chk("T1 w_z c2", int'(w_z), 0);
    reset = 1'b1;

    // T2: basic 1011
    feed("T2", 7'b0001011, 7'b0000001, 7'b0000001, 4);
    chk("T2 count_ov", int'(count_ov), 1);
    chk("T2 armed_no", int'(armed_no), 0);
    drive(1'b0, 1'b0, 1'b0);
    chk("T2 w_ov idle", int'(w_ov), 0);
    chk("T2 count_ov idle", int'(count_ov), 1);

    // T3: overlapping vs non-overlapping on 1011011
    do_clear();
    chk("T3 clear count", int'(count_ov), 0);
    feed("T3", 7'b1011011, 7'b0001001, 7'b0001000, 7);
    chk("T3 count_ov", int'(count_ov), 2);
    chk("T3 count_no", int'(count_no), 1);
    chk("T3 armed_no", int'(armed_no), 0);

    // T4: ready gaps are ignored
    do_clear();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk($sformatf("T4 w gap%0d", i), int'(w_ov), 0);
      chk($sformatf("T4 armed gap%0d", i), int'(armed_ov), 0);
    end
    drive(1'b1, 1'b1, 1'b0);
    chk("T4 w bit3", int'(w_ov), 0);
    drive(1'b1, 1'b1, 1'b0);
    chk("T4 w bit4", int'(w_ov), 1);
    chk("T4 count", int'(count_ov), 1);
    chk("T4 w_z", int'(w_z), 0);

    // T5: fill guard for PATTERN=0, then saturation of the 2-bit counter
    do_clear();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      chk($sformatf("T5 w_z bit%0d", i), int'(w_z), 0);
    end
    drive(1'b0, 1'b1, 1'b0);
    chk("T5 w_z bit4", int'(w_z), 1);
    chk("T5 count_z 1", int'(count_z), 1);
    for (int i = 5; i <= 8; i++) drive(1'b0, 1'b1, 1'b0);
    chk("T5 count_z sat", int'(count_z), 3);
    chk("T5 w_z bit8", int'(w_z), 1);
    chk("T5 w_ov zeros", int'(w_ov), 0);

    // T6a: asynchronous reset mid-sequence
    do_clear();
    feed("T6", 7'b0001011, 7'b0000001, 7'b0000001, 4);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("T6 count pre-reset", int'(count_ov), 1);
    #2 reset = 1'b0;
    #1;
    chk("T6 count async", int'(count_ov), 0);
    chk("T6 armed async", int'(armed_ov), 0);
    #1 reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0);
    chk("T6 w after reset", int'(w_ov), 0);
    chk("T6 count after reset", int'(count_ov), 0);

    // T6b: clear on the edge that would complete a match
    do_clear();
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    chk("T6 clear w", int'(w_ov), 0);
    chk("T6 clear count", int'(count_ov), 0);
    chk("T6 clear armed", int'(armed_ov), 0);
    clear = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
